// File: rtl/qspi_tx_sequencer.sv
// QSPI TX sequencer: pops 32-bit words from the TX fifo and presents them
// byte-serially (little-endian) to the shift engine for a programmed length.
module qspi_tx_sequencer #(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned STALL_MAX = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             abort,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_data_out,
    input  logic             fifo_empty,
    output logic             byte_valid,
    output logic [7:0]       byte_data,
    input  logic             byte_ready,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic [LEN_W-1:0] bytes_left
);

    localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t             state;
    logic [31:0]        word;
    logic [1:0]         idx;
    logic [STALL_W-1:0] stall_cnt;

    // Pop strobe must never fire on an empty fifo, so it is a direct decode.
    assign fifo_rd_en = (state == FETCH) && !fifo_empty;
    assign byte_valid = (state == SEND);
    assign byte_data  = word[{idx, 3'b000} +: 8];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            word       <= '0;
            idx        <= '0;
            stall_cnt  <= '0;
            done       <= 1'b0;
            underflow  <= 1'b0;
            bytes_left <= '0;
        end else begin
            done      <= 1'b0;
            underflow <= 1'b0;
            // abort wins over everything, including a final-byte handshake
            if (abort && (state != IDLE)) begin
                state      <= IDLE;
                bytes_left <= '0;
                stall_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (xfer_len == '0) begin
                                done <= 1'b1;
                            end else begin
                                bytes_left <= xfer_len;
                                stall_cnt  <= '0;
                                state      <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        if (!fifo_empty) begin
                            stall_cnt <= '0;
                            state     <= WAIT;
                        end else if (stall_cnt == STALL_W'(STALL_MAX - 1)) begin
                            underflow  <= 1'b1;
                            bytes_left <= '0;
                            stall_cnt  <= '0;
                            state      <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
                    WAIT: begin
                        word  <= fifo_data_out;
                        idx   <= '0;
                        state <= SEND;
                    end
                    SEND: begin
                        if (byte_ready) begin
                            bytes_left <= bytes_left - LEN_W'(1);
                            idx        <= idx + 2'd1;
                            // leftover bytes of a final partial word are dropped
                            if (bytes_left == LEN_W'(1)) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else if (idx == 2'd3) begin
                                state <= FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_tx_sequencer.sv
// Bench for qspi_tx_sequencer: fifo model, byte/event scoreboard fed by the
// stimulus, and a negedge monitor that pops and compares.
module tb_qspi_tx_sequencer;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned STALL_MAX = 8;
    localparam int          EV_DONE   = 1;
    localparam int          EV_UNDER  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] xfer_len = '0;
    logic             abort = 1'b0;
    logic             fifo_rd_en;
    logic [31:0]      fifo_data_out = '0;
    logic             fifo_empty;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             underflow;
    logic [LEN_W-1:0] bytes_left;

    int vectors = 0;
    int miscompares = 0;

    qspi_tx_sequencer #(.LEN_W(LEN_W), .STALL_MAX(STALL_MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .xfer_len     (xfer_len),
        .abort        (abort),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .busy         (busy),
        .done         (done),
        .underflow    (underflow),
        .bytes_left   (bytes_left)
    );

    always #5 clk = ~clk;

    // Fifo model: registered read data, one cycle after the pop strobe.
    logic [31:0] fmem [0:63];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    int  pop_cnt = 0;
    logic hold_empty = 1'b0;
    logic flush_req = 1'b0;
    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_data_out <= fmem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
            pop_cnt       <= pop_cnt + 1;
        end
    end

    // Shift-engine ready: 0 always 1, 1 alternating, 2 random, 3 held low.
    int rmode = 0;
    always @(posedge clk) begin
        #2;
        case (rmode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = !byte_ready;
            2:       byte_ready = 1'($urandom_range(0, 1));
            default: byte_ready = 1'b0;
        endcase
    end

    // Short random empty bursts, never long enough to trip the stall timeout.
    int hmode = 0;
    int hold_run = 0;
    always @(posedge clk) begin
        #2;
        if ((hmode != 0) && (hold_run < 3) && ($urandom_range(0, 3) == 0)) begin
            hold_empty = 1'b1;
            hold_run++;
        end else begin
            hold_empty = 1'b0;
            hold_run   = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [7:0] exp_q[$];
    int         ev_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && byte_valid)
                check("byte_hold", byte_data, prev_byte);
            if (byte_valid && byte_ready && !abort) begin
                if (exp_q.size() == 0) check("unexpected_byte", byte_data, 32'hxxxx_xxxx);
                else                   check("byte", byte_data, exp_q.pop_front());
            end
            if (done || underflow) begin
                if (ev_q.size() == 0) check("unexpected_event", {underflow, done}, 0);
                else                  check("event", {underflow, done}, ev_q.pop_front());
            end
            prev_stall = byte_valid && !byte_ready && !abort;
            prev_byte  = byte_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [31:0] wq[$];

    task automatic push_word(input logic [31:0] w);
        fmem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic flush_fifo();
        @(posedge clk); #2 flush_req = 1'b1;
        @(posedge clk); #2 flush_req = 1'b0;
    endtask

    task automatic pulse_start(input int len, input logic with_abort);
        @(posedge clk); #2;
        start    = 1'b1;
        abort    = with_abort;
        xfer_len = LEN_W'(len);
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", busy, 0);
        @(negedge clk);
        check("bytes_drained", exp_q.size(), 0);
        check("events_drained", ev_q.size(), 0);
    endtask

    // Reference: the byte stream is the first len bytes of the words, LSB first.
    task automatic run_xfer(input int len, input logic lat_chk);
        int p0;
        foreach (wq[k]) push_word(wq[k]);
        for (int i = 0; i < len; i++)
            exp_q.push_back(8'(wq[i / 4] >> (8 * (i % 4))));
        ev_q.push_back(EV_DONE);
        p0 = pop_cnt;
        pulse_start(len, 1'b0);
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("bytes_left_loaded", bytes_left, len);
        if (lat_chk) begin
            check("rd_en_cycle1", fifo_rd_en, 1);
            @(negedge clk);
            check("valid_cycle2", byte_valid, 0);
            @(negedge clk);
            check("valid_cycle3", byte_valid, 1);
        end
        wait_idle(3000);
        check("pop_count", pop_cnt - p0, (len + 3) / 4);
        wq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int p0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", byte_valid, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_done", done, 0);
        check("rst_underflow", underflow, 0);
        check("rst_bytes_left", bytes_left, 0);
        check("rst_byte_data", byte_data, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Full two-word transfer, ready always high
        rmode = 0;
        wq = '{32'h4433_2211, 32'h8877_6655};
        run_xfer(8, 1'b1);

        // Partial final word: only 5 bytes leave, remainder discarded
        wq = '{32'h4433_2211, 32'h8877_6655};
        run_xfer(5, 1'b1);

        // Backpressure: byte must hold while not accepted
        rmode = 1;
        wq = '{32'h4433_2211, 32'h8877_6655};
        run_xfer(8, 1'b1);
        rmode = 0;

        // Empty fifo: underflow after STALL_MAX empty FETCH cycles
        ev_q.push_back(EV_UNDER);
        p0 = pop_cnt;
        pulse_start(4, 1'b0);
        @(negedge clk);
        for (int i = 0; i < int'(STALL_MAX); i++) begin
            check("stall_busy", busy, 1);
            check("stall_no_pop", fifo_rd_en, 0);
            @(negedge clk);
        end
        check("underflow_busy", busy, 0);
        check("underflow_pulse", underflow, 1);
        check("underflow_no_done", done, 0);
        check("underflow_bytes_left", bytes_left, 0);
        @(negedge clk);
        check("underflow_single", underflow, 0);
        check("events_drained", ev_q.size(), 0);

        // Zero length: done next cycle, no pop
        ev_q.push_back(EV_DONE);
        pulse_start(0, 1'b0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_no_pop", fifo_rd_en, 0);
        @(negedge clk);
        check("events_drained", ev_q.size(), 0);
        check("len0_pops", pop_cnt - p0, 0);

        // start with abort in the same cycle is dropped
        pulse_start(0, 1'b1);
        @(negedge clk);
        check("start_abort_len0_done", done, 0);
        pulse_start(4, 1'b1);
        @(negedge clk);
        check("start_abort_busy", busy, 0);

        // Abort after the second byte is accepted
        wq = '{32'h4433_2211, 32'h8877_6655};
        foreach (wq[k]) push_word(wq[k]);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(wq[i / 4] >> (8 * (i % 4))));
        wq.delete();
        pulse_start(8, 1'b0);
        n = 0;
        while ((exp_q.size() > 6) && (n < 50)) begin
            @(posedge clk); #2;
            n++;
        end
        check("abort_reached_byte2", exp_q.size(), 6);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", byte_valid, 0);
        check("abort_no_done", done, 0);
        check("abort_bytes_left", bytes_left, 0);
        check("abort_rd_en", fifo_rd_en, 0);
        flush_fifo();
        wq = '{32'hDDCC_BBAA};
        run_xfer(4, 1'b1);

        // Randomised transfers with random backpressure and fifo gaps
        rmode = 2;
        hmode = 1;
        for (int t = 0; t < 12; t++) begin
            len = $urandom_range(1, 20);
            for (int w = 0; w < (len + 3) / 4; w++) wq.push_back($urandom);
            run_xfer(len, 1'b0);
        end
        hmode = 0;

        // Reset held for two cycles in the middle of SEND
        rmode = 3;
        push_word(32'h4433_2211);
        push_word(32'h8877_6655);
        pulse_start(8, 1'b0);
        n = 0;
        while (!byte_valid && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("reached_send", byte_valid, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", byte_valid, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        check("midrst_done", done, 0);
        check("midrst_bytes_left", bytes_left, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        flush_fifo();
        rmode = 0;
        wq = '{32'h0BAD_F00D};
        run_xfer(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
